twd_seq_ctrl: RTL and testbench

TWD_SEQ_CTRL -- requirements
Module: twd_seq_ctrl

---
 rtl/fft_pkg.sv | 14 +
 rtl/valid_delay.sv | 41 ++++
 rtl/twd_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_twd_seq_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT twiddle sequencing logic.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_CLK_CNT = 16;
  localparam int DEF_IDX_DIV = 4;
  localparam int DEF_LATENCY = 1;

endpackage : fft_pkg

// File: rtl/valid_delay.sv
// LATENCY-deep {valid, last} shift register that tracks beats through the
// twiddle multiplier pipeline. Async reset, synchronous clear for aborts.
module valid_delay
  import fft_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] last_q;

  // Shift one stage per cycle; a clear wipes every in-flight beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      last_q[0]  <= last_i & valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign last_o  = last_q[LATENCY-1];

endmodule : valid_delay

// File: rtl/twd_seq_ctrl.sv
// Twiddle-factor sequencer: counts butterfly beats within a frame, selects
// the twiddle index per beat and tracks results through the multiplier.
module twd_seq_ctrl
  import fft_pkg::*;
#(
  parameter int CLK_CNT = DEF_CLK_CNT,
  parameter int IDX_DIV = DEF_IDX_DIV,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic       i_flush,
  output logic       o_twd_valid,
  output logic [3:0] o_twd_idx,
  output logic [3:0] o_beat_cnt,
  output logic       o_out_valid,
  output logic       o_eof,
  output logic       o_busy,
  output logic       o_err,
  output logic [7:0] o_frame_cnt
);

  localparam logic [3:0] LAST_BEAT = 4'(CLK_CNT - 1);
  localparam logic [3:0] IDX_DIV_W = 4'(IDX_DIV);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       err_q, err_d;

  logic       accept;
  logic [3:0] beat_cur;
  logic       is_last;
  logic       dly_clr;
  logic       dly_valid;
  logic       dly_last;

  // Register state, beat counter, frame counter and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      frame_cnt_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // Decide beat acceptance, current beat number and next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    accept      = 1'b0;
    beat_cur    = cnt_q;
    dly_clr     = 1'b0;
    is_last     = 1'b0;

    if (i_flush) begin
      // Flush wins over everything; a coincident beat is silently dropped.
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      dly_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            if (i_sof) begin
              accept   = 1'b1;
              beat_cur = 4'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_valid) begin
            accept = 1'b1;
            // A fresh sof mid-frame abandons the partial frame.
            if (i_sof && (cnt_q != 4'd0)) begin
              err_d    = 1'b1;
              beat_cur = 4'd0;
            end
          end
        end
        ST_DRAIN: begin
          // Leave once the tagged last beat leaves the pipeline.
          if (dly_last) state_d = ST_IDLE;
          if (i_valid) begin
            if (i_sof) begin
              accept   = 1'b1;
              beat_cur = 4'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept) begin
        if (beat_cur == LAST_BEAT) begin
          is_last     = 1'b1;
          cnt_d       = 4'd0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = ST_DRAIN;
        end else begin
          cnt_d   = beat_cur + 4'd1;
          state_d = ST_RUN;
        end
      end
    end
  end

  valid_delay #(
    .LATENCY(LATENCY)
  ) u_valid_delay (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (dly_clr),
    .valid_i(accept),
    .last_i (is_last),
    .valid_o(dly_valid),
    .last_o (dly_last)
  );

  assign o_twd_valid = accept;
  assign o_beat_cnt  = beat_cur;
  assign o_twd_idx   = beat_cur / IDX_DIV_W;
  assign o_out_valid = dly_valid;
  assign o_eof       = dly_last;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_err       = err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule : twd_seq_ctrl

// File: tb/tb_twd_seq_ctrl.sv
// Self-checking bench for twd_seq_ctrl: directed scenarios plus random
// traffic, all compared against a frame-level reference model.
module tb_twd_seq_ctrl;

  localparam int CLK_CNT = 16;
  localparam int IDX_DIV = 4;
  localparam int LATENCY = 1;

  logic       clk;
  logic       rstn;
  logic       i_valid;
  logic       i_sof;
  logic       i_flush;
  logic       o_twd_valid;
  logic [3:0] o_twd_idx;
  logic [3:0] o_beat_cnt;
  logic       o_out_valid;
  logic       o_eof;
  logic       o_busy;
  logic       o_err;
  logic [7:0] o_frame_cnt;

  twd_seq_ctrl #(
    .CLK_CNT(CLK_CNT),
    .IDX_DIV(IDX_DIV),
    .LATENCY(LATENCY)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .i_flush    (i_flush),
    .o_twd_valid(o_twd_valid),
    .o_twd_idx  (o_twd_idx),
    .o_beat_cnt (o_beat_cnt),
    .o_out_valid(o_out_valid),
    .o_eof      (o_eof),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .o_frame_cnt(o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: frame-level view of the sequencer.
  typedef struct {
    int al;
    bit last;
  } res_t;

  int   cyc = 0;
  bit   m_in_frame = 0;
  int   m_next_beat = 0;
  int   m_frame = 0;
  bit   m_err_pend = 0;
  bit   m_drain = 0;
  int   m_last_cyc = 0;
  res_t m_q[$];

  // Per-scenario observation statistics.
  int   step = 0;
  int   n_twd = 0;
  int   n_err = 0;
  int   n_outv = 0;
  int   eof_steps[$];
  int   ov_first = -1;
  int   ov_last = -1;

  logic [20:0] exp_vec;
  logic [20:0] obs_vec;

  task automatic clear_stats();
    step = 0; n_twd = 0; n_err = 0; n_outv = 0;
    ov_first = -1; ov_last = -1;
    eof_steps.delete();
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_next_beat = 0; m_frame = 0;
    m_err_pend = 0; m_drain = 0;
    m_q.delete();
  endtask

  // Drive one cycle of inputs, form expectation, sample outputs, advance model.
  task automatic drive_cycle(input bit v, input bit s, input bit f);
    bit acc;
    bit errn;
    bit lst;
    bit exp_ov;
    bit exp_eof;
    bit busy;
    int beat;
    i_valid = v; i_sof = s; i_flush = f;
    acc = 0; errn = 0; beat = m_next_beat;
    if (!f) begin
      if (!m_in_frame) begin
        if (v && s) begin acc = 1; beat = 0; end
        else if (v) errn = 1;
      end else if (v) begin
        acc = 1;
        if (s && m_next_beat != 0) begin errn = 1; beat = 0; end
      end
    end
    exp_ov  = (m_q.size() > 0) && (m_q[0].al == cyc);
    exp_eof = exp_ov && m_q[0].last;
    busy    = m_in_frame || (m_drain && (cyc <= m_last_cyc + LATENCY));
    exp_vec = {acc, 4'(beat / IDX_DIV), 4'(beat), exp_ov, exp_eof, busy,
               m_err_pend, 8'(m_frame)};
    #4;
    obs_vec = {o_twd_valid, o_twd_idx, o_beat_cnt, o_out_valid, o_eof,
               o_busy, o_err, o_frame_cnt};
    n_twd += int'(o_twd_valid);
    n_err += int'(o_err);
    if (o_out_valid) begin
      n_outv++;
      if (ov_first < 0) ov_first = step;
      ov_last = step;
    end
    if (o_eof) eof_steps.push_back(step);
    if (exp_ov) void'(m_q.pop_front());
    m_err_pend = errn;
    if (f) begin
      m_in_frame = 0; m_next_beat = 0; m_drain = 0;
      m_q.delete();
    end else if (acc) begin
      lst = (beat == CLK_CNT - 1);
      m_q.push_back('{cyc + LATENCY, lst});
      if (lst) begin
        m_frame = (m_frame + 1) % 256;
        m_in_frame = 0; m_next_beat = 0;
        m_drain = 1; m_last_cyc = cyc;
      end else begin
        m_in_frame = 1; m_next_beat = beat + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    step++;
  endtask

  task automatic test_reset();
    i_valid = 0; i_sof = 0; i_flush = 0; rstn = 0;
    #3;
    obs_vec = {o_twd_valid, o_twd_idx, o_beat_cnt, o_out_valid, o_eof,
               o_busy, o_err, o_frame_cnt};
    checks++;
    if (obs_vec !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec, 21'd0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1;
    model_reset();
    clear_stats();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_contiguous();
    clear_stats();
    for (int k = 0; k < CLK_CNT + 3; k++) begin
      drive_cycle(k < CLK_CNT, k == 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL contig step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (eof_steps.size() != 1 || eof_steps[0] != CLK_CNT || o_frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL contig_eof got n_eof=%0d at=%0d frame=%0d exp n_eof=1 at=%0d frame=1",
               eof_steps.size(), eof_steps.size() > 0 ? eof_steps[0] : -1, o_frame_cnt, CLK_CNT);
    end
    $display("test_contiguous done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stall();
    int beat;
    clear_stats();
    beat = 0;
    for (int k = 0; k < CLK_CNT + 6; k++) begin
      bit v;
      v = (k < CLK_CNT + 3) && !(k >= 5 && k <= 7);
      drive_cycle(v, v && beat == 0, 0);
      if (v) beat++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL stall step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (n_twd != CLK_CNT || n_err != 0 || n_outv != CLK_CNT || eof_steps.size() != 1
        || o_frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL stall_summary got twd=%0d err=%0d outv=%0d eof=%0d frame=%0d exp 16 0 16 1 2",
               n_twd, n_err, n_outv, eof_steps.size(), o_frame_cnt);
    end
    $display("test_stall done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int k = 0; k < 2 * CLK_CNT + 3; k++) begin
      drive_cycle(k < 2 * CLK_CNT, k == 0 || k == CLK_CNT, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (n_outv != 32 || ov_first != 1 || ov_last != 32 || eof_steps.size() != 2
        || eof_steps[0] != 16 || eof_steps[1] != 32 || o_frame_cnt !== 8'd4) begin
      errors++;
      $display("FAIL b2b_summary got outv=%0d first=%0d last=%0d eof=%0d frame=%0d exp 32 1 32 2 4",
               n_outv, ov_first, ov_last, eof_steps.size(), o_frame_cnt);
    end
    $display("test_back_to_back done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_sof_restart();
    clear_stats();
    // Beats 0..8, then sof in place of beat 9, then a full frame from there.
    for (int k = 0; k < 9 + CLK_CNT + 3; k++) begin
      drive_cycle(k < 9 + CLK_CNT, k == 0 || k == 9, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL restart step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      if (k == 9) begin
        checks++;
        if (o_beat_cnt !== 4'd0) begin
          errors++;
          $display("FAIL restart_cnt got=%0d exp=0", o_beat_cnt);
        end
      end
    end
    checks++;
    if (n_err != 1 || eof_steps.size() != 1 || eof_steps[0] != 9 + CLK_CNT
        || o_frame_cnt !== 8'd5) begin
      errors++;
      $display("FAIL restart_summary got err=%0d eof=%0d frame=%0d exp 1 1 5",
               n_err, eof_steps.size(), o_frame_cnt);
    end
    $display("test_sof_restart done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_idle_err();
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      drive_cycle(k == 1, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL idle_err step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (n_twd != 0 || n_err != 1) begin
      errors++;
      $display("FAIL idle_err_summary got twd=%0d err=%0d exp 0 1", n_twd, n_err);
    end
    $display("test_idle_err done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flush_reset();
    clear_stats();
    // Frame A: beats 0..5, flush coincident with beat 6, two idle cycles.
    for (int k = 0; k < 9; k++) begin
      drive_cycle(k <= 6, k == 0, k == 6);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL flush step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (o_busy !== 1'b0 || o_beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL flush_idle got busy=%0d cnt=%0d exp 0 0", o_busy, o_beat_cnt);
    end
    // Frame B: beats 0..9, then reset lands during beat 10.
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1, k == 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL pre_reset step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    i_valid = 1; i_sof = 0; i_flush = 0;
    #1;
    i_valid = 0; rstn = 0;
    #2;
    obs_vec = {o_twd_valid, o_twd_idx, o_beat_cnt, o_out_valid, o_eof,
               o_busy, o_err, o_frame_cnt};
    checks++;
    if (obs_vec !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec, 21'd0);
    end
    @(posedge clk); #1;
    rstn = 1;
    cyc++;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL post_reset step=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (eof_steps.size() != 0 || n_err != 0) begin
      errors++;
      $display("FAIL flush_reset_summary got eof=%0d err=%0d exp 0 0", eof_steps.size(), n_err);
    end
    $display("test_flush_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    clear_stats();
    for (int k = 0; k < 1500; k++) begin
      bit v;
      bit s;
      bit f;
      v = ($urandom_range(0, 9) < 8);
      s = m_in_frame ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 99) == 0);
      drive_cycle(v, s, f);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random step=%0d v=%0d s=%0d f=%0d got=%h exp=%h",
                 k, v, s, f, obs_vec, exp_vec);
      end
    end
    $display("test_random done checks=%0d errors=%0d frames=%0d", checks, errors, o_frame_cnt);
  endtask

  initial begin
    i_valid = 0; i_sof = 0; i_flush = 0; rstn = 0;
    test_reset();
    test_contiguous();
    test_stall();
    test_back_to_back();
    test_sof_restart();
    test_idle_err();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule : tb_twd_seq_ctrl
